// File: rtl/leaf_sched_pkg.sv
// Shared types and constants for the leaf router crossbar scheduler.
// Requester and output-port indices share one numbering: 0 = GPU, 1..4 = spines.
package leaf_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOCK = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    localparam int NUM_REQ = 5;
    localparam int DEST_W  = 6;

    localparam logic [2:0] REQ_GPU    = 3'd0;
    localparam logic [2:0] REQ_SPINE1 = 3'd1;
    localparam logic [2:0] REQ_SPINE2 = 3'd2;
    localparam logic [2:0] REQ_SPINE3 = 3'd3;
    localparam logic [2:0] REQ_SPINE4 = 3'd4;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;
    localparam logic [1:0] DIR_DROP = 2'b11;

    localparam logic [2:0] NONE_GRANT = 3'b111;

    // Reduce a small sum (at most 8 for in-range operands) back into 0..4.
    function automatic logic [2:0] wrap5(input logic [3:0] v);
        if (v >= 4'd5) begin
            return 3'(v - 4'd5);
        end
        return v[2:0];
    endfunction

    function automatic logic [2:0] next_req(input logic [2:0] g);
        return wrap5({1'b0, g} + 4'd1);
    endfunction

endpackage

// File: rtl/leaf_xbar_scheduler_rr_picker5.sv
// Combinational 5-way round-robin picker: first set request at or after ptr,
// wrapping modulo 5. ptr must be in 0..4.
module rr_picker5
    import leaf_sched_pkg::*;
(
    input  logic [4:0] req,
    input  logic [2:0] ptr,
    output logic [4:0] pick,
    output logic [2:0] idx,
    output logic       valid
);

    logic [2:0] pos [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_pos
            assign pos[gi] = wrap5({1'b0, ptr} + 4'(gi));
        end
    endgenerate

    // Scan from farthest to nearest so the nearest set request overwrites.
    always_comb begin
        pick = '0;
        idx  = NONE_GRANT;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[pos[k]]) begin
                pick         = '0;
                pick[pos[k]] = 1'b1;
                idx          = pos[k];
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/leaf_xbar_scheduler.sv
// Packet-level round-robin scheduler for the leaf crossbar: locks one requester
// for a fixed-length packet, routes it from its destination and paces beats.
module leaf_xbar_scheduler
    import leaf_sched_pkg::*;
#(
    parameter logic [3:0] GROUP_ID = 4'b0110,
    parameter int         PKT_LEN  = 4,
    parameter int         TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arb_enable,
    input  logic [4:0]  req_valid,
    input  logic [29:0] req_dest,
    input  logic [4:0]  dst_ready,
    output logic [4:0]  req_ready,
    output logic [4:0]  grant,
    output logic [4:0]  out_sel,
    output logic [2:0]  current_grant,
    output logic [1:0]  direction,
    output logic        busy,
    output logic        drop_pulse,
    output logic        timeout_pulse
);

    localparam int BEAT_W  = $clog2(PKT_LEN + 1);
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    state_t             state_reg;
    logic [2:0]         rr_ptr_reg;
    logic [BEAT_W-1:0]  beat_cnt_reg;
    logic [STALL_W-1:0] stall_reg;
    logic [4:0]         grant_reg;
    logic [4:0]         out_sel_reg;
    logic [2:0]         current_grant_reg;
    logic [1:0]         direction_reg;
    logic               drop_pulse_reg;
    logic               timeout_pulse_reg;

    logic [4:0]          pick_onehot;
    logic [2:0]          pick_idx;
    logic                pick_valid;
    logic [DEST_W-1:0]   sel_dest;
    logic [4:0]          route_sel;
    logic [1:0]          route_dir;
    logic                is_drop;
    logic                dst_ok;
    logic                accept;
    logic [BEAT_W-1:0]   beat_inc;
    logic [STALL_W-1:0]  stall_inc;
    logic                last_beat;
    logic                stall_limit;

    rr_picker5 u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr_reg),
        .pick  (pick_onehot),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Route the candidate chosen this cycle; only registered when a grant is taken.
    always_comb begin
        sel_dest  = '0;
        route_sel = '0;
        route_dir = DIR_DROP;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) begin
                sel_dest = req_dest[DEST_W*i +: DEST_W];
            end
        end
        if (pick_onehot[REQ_GPU]) begin
            route_sel = 5'b00001 << ({1'b0, sel_dest[1:0]} + 3'd1);
            route_dir = DIR_UP;
        end else if (sel_dest[5:2] == GROUP_ID) begin
            route_sel = 5'b00001;
            route_dir = DIR_DOWN;
        end
    end

    // A dropped packet is sunk regardless of output readiness.
    always_comb begin
        is_drop   = (direction_reg == DIR_DROP);
        dst_ok    = |(dst_ready & out_sel_reg);
        req_ready = '0;
        if (state_reg == ST_XFER && (dst_ok || is_drop)) begin
            req_ready = req_valid & grant_reg;
        end
        accept      = |req_ready;
        beat_inc    = beat_cnt_reg + BEAT_W'(1);
        stall_inc   = stall_reg + STALL_W'(1);
        last_beat   = accept && (beat_inc == BEAT_W'(PKT_LEN));
        stall_limit = !accept && (stall_inc == STALL_W'(TIMEOUT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= ST_IDLE;
            rr_ptr_reg        <= '0;
            beat_cnt_reg      <= '0;
            stall_reg         <= '0;
            grant_reg         <= '0;
            out_sel_reg       <= '0;
            current_grant_reg <= NONE_GRANT;
            direction_reg     <= DIR_IDLE;
            drop_pulse_reg    <= 1'b0;
            timeout_pulse_reg <= 1'b0;
        end else begin
            drop_pulse_reg    <= 1'b0;
            timeout_pulse_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (arb_enable && pick_valid) begin
                        state_reg         <= ST_LOCK;
                        grant_reg         <= pick_onehot;
                        current_grant_reg <= pick_idx;
                        out_sel_reg       <= route_sel;
                        direction_reg     <= route_dir;
                        beat_cnt_reg      <= '0;
                        stall_reg         <= '0;
                    end
                end
                ST_LOCK: begin
                    state_reg <= ST_XFER;
                end
                ST_XFER: begin
                    // An accepted beat clears the stall path, so last_beat and
                    // stall_limit can never fire together.
                    if (last_beat || stall_limit) begin
                        state_reg         <= ST_IDLE;
                        rr_ptr_reg        <= next_req(current_grant_reg);
                        grant_reg         <= '0;
                        out_sel_reg       <= '0;
                        current_grant_reg <= NONE_GRANT;
                        direction_reg     <= DIR_IDLE;
                        beat_cnt_reg      <= '0;
                        stall_reg         <= '0;
                        drop_pulse_reg    <= last_beat && is_drop;
                        timeout_pulse_reg <= stall_limit;
                    end else if (accept) begin
                        beat_cnt_reg <= beat_inc;
                        stall_reg    <= '0;
                    end else begin
                        stall_reg <= stall_inc;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant         = grant_reg;
    assign out_sel       = out_sel_reg;
    assign current_grant = current_grant_reg;
    assign direction     = direction_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign drop_pulse    = drop_pulse_reg;
    assign timeout_pulse = timeout_pulse_reg;

endmodule

// File: tb/tb_leaf_xbar_scheduler.sv
// Directed bench for leaf_xbar_scheduler with immediate-assertion checks.
module tb_leaf_xbar_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        arb_enable;
    logic [4:0]  req_valid;
    logic [29:0] req_dest;
    logic [4:0]  dst_ready;
    logic [4:0]  req_ready;
    logic [4:0]  grant;
    logic [4:0]  out_sel;
    logic [2:0]  current_grant;
    logic [1:0]  direction;
    logic        busy;
    logic        drop_pulse;
    logic        timeout_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    leaf_xbar_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .arb_enable    (arb_enable),
        .req_valid     (req_valid),
        .req_dest      (req_dest),
        .dst_ready     (dst_ready),
        .req_ready     (req_ready),
        .grant         (grant),
        .out_sel       (out_sel),
        .current_grant (current_grant),
        .direction     (direction),
        .busy          (busy),
        .drop_pulse    (drop_pulse),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-18s observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        reset      = 1'b1;
        arb_enable = 1'b0;
        req_valid  = '0;
        req_dest   = '0;
        dst_ready  = '0;
        step();
        step();
        chk("rst_grant", {3'b0, grant}, 8'h00);
        chk("rst_cur", {5'b0, current_grant}, 8'h07);
        chk("rst_dir", {6'b0, direction}, 8'h00);
        chk("rst_busy", {7'b0, busy}, 8'h00);
        chk("rst_outsel", {3'b0, out_sel}, 8'h00);
        reset = 1'b0;

        // GPU to spine2 (dest[1:0]=01), all outputs ready
        arb_enable = 1'b1;
        dst_ready  = 5'b11111;
        req_dest   = {6'b011000, 6'b011011, 6'b011010, 6'b011001, 6'b011001};
        req_valid  = 5'b00001;
        step();
        chk("gpu_grant", {3'b0, grant}, 8'h01);
        chk("gpu_cur", {5'b0, current_grant}, 8'h00);
        chk("gpu_dir", {6'b0, direction}, 8'h01);
        chk("gpu_outsel", {3'b0, out_sel}, 8'h04);
        chk("gpu_lock_rdy", {3'b0, req_ready}, 8'h00);
        chk("gpu_busy", {7'b0, busy}, 8'h01);
        for (int b = 0; b < 4; b++) begin
            step();
            chk("gpu_beat_rdy", {3'b0, req_ready}, 8'h01);
        end
        step();
        req_valid = '0;
        chk("gpu_end_cur", {5'b0, current_grant}, 8'h07);
        chk("gpu_end_grant", {3'b0, grant}, 8'h00);
        chk("gpu_end_busy", {7'b0, busy}, 8'h00);

        // Fresh reset so the round-robin sequence starts at requester 0
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_valid = 5'b11111;
        begin
            logic [2:0] order [6];
            order = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
            for (int p = 0; p < 6; p++) begin
                step();
                chk("rr_grant", {3'b0, grant}, 8'(5'b00001 << order[p]));
                chk("rr_cur", {5'b0, current_grant}, {5'b0, order[p]});
                chk("rr_dir", {6'b0, direction}, (order[p] == 3'd0) ? 8'h01 : 8'h02);
                chk("rr_outsel", {3'b0, out_sel}, (order[p] == 3'd0) ? 8'h04 : 8'h01);
                for (int c = 0; c < 4; c++) begin
                    step();
                    chk("rr_hold", {3'b0, grant}, 8'(5'b00001 << order[p]));
                end
                step();
                chk("rr_gap", {3'b0, grant}, 8'h00);
            end
        end
        req_valid = '0;

        // Spine2 to foreign group: dropped, no output readiness needed
        dst_ready = '0;
        req_dest[17:12] = 6'b010100;
        req_valid = 5'b00100;
        step();
        chk("drop_grant", {3'b0, grant}, 8'h04);
        chk("drop_dir", {6'b0, direction}, 8'h03);
        chk("drop_outsel", {3'b0, out_sel}, 8'h00);
        step();
        for (int b = 0; b < 4; b++) begin
            chk("drop_rdy", {3'b0, req_ready}, 8'h04);
            chk("drop_pulse_early", {7'b0, drop_pulse}, 8'h00);
            step();
        end
        req_valid = '0;
        chk("drop_pulse", {7'b0, drop_pulse}, 8'h01);
        chk("drop_end_grant", {3'b0, grant}, 8'h00);
        step();
        chk("drop_pulse_clr", {7'b0, drop_pulse}, 8'h00);

        // GPU stalls on spine2 port; spine1 waits behind it
        dst_ready = 5'b11011;
        req_dest[11:6] = 6'b011000;
        req_valid = 5'b00011;
        step();
        chk("to_grant", {3'b0, grant}, 8'h01);
        for (int c = 0; c < 16; c++) begin
            step();
        end
        chk("to_busy_pre", {7'b0, busy}, 8'h01);
        chk("to_pulse_pre", {7'b0, timeout_pulse}, 8'h00);
        chk("to_rdy_stall", {3'b0, req_ready}, 8'h00);
        step();
        chk("to_pulse", {7'b0, timeout_pulse}, 8'h01);
        chk("to_busy", {7'b0, busy}, 8'h00);
        chk("to_grant_clr", {3'b0, grant}, 8'h00);
        step();
        req_valid = 5'b00010;
        chk("to_next_grant", {3'b0, grant}, 8'h02);
        chk("to_next_dir", {6'b0, direction}, 8'h02);
        chk("to_pulse_clr", {7'b0, timeout_pulse}, 8'h00);
        for (int c = 0; c < 5; c++) begin
            step();
        end
        req_valid = '0;
        chk("sp1_done", {3'b0, grant}, 8'h00);
        chk("sp1_no_to", {7'b0, timeout_pulse}, 8'h00);

        // Asynchronous reset in the middle of beat 2
        dst_ready = 5'b11111;
        req_valid = 5'b00001;
        step();
        step();
        step();
        chk("mid_rdy", {3'b0, req_ready}, 8'h01);
        reset = 1'b1;
        arb_enable = 1'b0;
        req_valid = 5'b11111;
        req_dest[5:0] = 6'b011010;
        #1;
        chk("arst_grant", {3'b0, grant}, 8'h00);
        chk("arst_cur", {5'b0, current_grant}, 8'h07);
        chk("arst_busy", {7'b0, busy}, 8'h00);
        chk("arst_rdy", {3'b0, req_ready}, 8'h00);
        chk("arst_dir", {6'b0, direction}, 8'h00);
        step();
        reset = 1'b0;

        // Arbitration disabled: nothing granted
        for (int c = 0; c < 3; c++) begin
            step();
            chk("dis_grant", {3'b0, grant}, 8'h00);
            chk("dis_busy", {7'b0, busy}, 8'h00);
        end
        arb_enable = 1'b1;
        step();
        chk("en_grant", {3'b0, grant}, 8'h01);
        chk("en_outsel", {3'b0, out_sel}, 8'h08);
        arb_enable = 1'b0;
        req_valid = 5'b00001;
        for (int b = 0; b < 4; b++) begin
            step();
            chk("dis_mid_rdy", {3'b0, req_ready}, 8'h01);
        end
        step();
        chk("dis_mid_done", {3'b0, grant}, 8'h00);
        chk("dis_mid_busy", {7'b0, busy}, 8'h00);
        step();
        chk("dis_no_regrant", {3'b0, grant}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
